// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the store path and the transmit FSM; dout shows the head entry combinationally.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A push while full is refused even if a pop frees a slot this same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmitter: queues stored bytes and sends them as 8N1 frames on tx.
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1 frame).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); pops the next byte straight into START if one is queued
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_we,
    input  logic [7:0] uart,
    output logic       stall,
    output logic       tx,
    output logic       busy
);

    localparam int            CPB       = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int            CW        = $clog2(CPB);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_empty, fifo_full;
    logic       bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (uart_we),
        .din   (uart),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign stall   = uart_we && fifo_full;
    assign bit_end = (baud_cnt_q == BAUD_LAST);
    assign tx      = tx_q;
    assign busy    = busy_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^fifo_dout;
`endif
                    baud_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // tx follows the registered state, so the line lags the state by one clock.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE) || !fifo_empty || (uart_we && !fifo_full);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule
